// File: rtl/bram_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// bram_uart_cmd_ctrl
//
// Purpose:
//   This block sits between the UART byte streams and a single-port block RAM.
//   It parses host command frames from the RX stream:
//     CMD, ADDR_HI, ADDR_LO, LEN [, data bytes for writes]
//
//   CMD 0x57 ('W'):
//     - Writes LEN+1 bytes into RAM, starting at {ADDR_HI, ADDR_LO}.
//     - The address auto-increments modulo 2^RAM_ADDR_BITS.
//     - When the burst is complete, the block sends the ACK byte 0x06.
//   CMD 0x52 ('R'):
//     - Reads LEN+1 bytes from RAM.
//     - Each read byte goes to the TX path with a valid/ready handshake.
//   Any other byte received in IDLE is discarded.
//
//   This block is the only master of the RAM port. The RAM has a 1-cycle
//   registered read latency. bram_we and bram_re are registered one-cycle
//   pulses, and they are never asserted together.
//
// Optional feature (macro RX_TIMEOUT_EN):
//   - An inter-byte RX timeout of TIMEOUT_CYCLES clocks applies to the header
//     states and to WR_DATA.
//   - When the timeout expires, the block returns to IDLE and sends no ACK.
//   - Read states are never timed out.
//   - Without the macro, no counter exists and these states wait indefinitely.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_data     received UART byte
//   rx_valid    one-cycle strobe; rx_data is valid while it is high
//   tx_data     byte to transmit
//   tx_valid    tx_data is valid; held high until accepted
//   tx_ready    TX path accepts the byte when tx_valid && tx_ready
//   bram_we     RAM write enable
//   bram_re     RAM read enable
//   bram_addr   RAM address
//   bram_wdata  RAM write data
//   bram_rdata  RAM read data, valid one cycle after bram_re
//   busy        high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module bram_uart_cmd_ctrl #(
  parameter int RAM_ADDR_BITS  = 13,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     bram_we,
  output logic                     bram_re,
  output logic [RAM_ADDR_BITS-1:0] bram_addr,
  output logic [7:0]               bram_wdata,
  input  logic [7:0]               bram_rdata,
  output logic                     busy
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  typedef enum logic [3:0] {
    IDLE,
    GET_AH,
    GET_AL,
    GET_LEN,
    WR_DATA,
    WR_ACK,
    RD_REQ,
    RD_WAIT,
    RD_SEND
  } state_t;

  state_t                   state, state_next;
  logic [RAM_ADDR_BITS-1:0] addr, addr_next;
  logic [RAM_ADDR_BITS-1:0] addr_inc;
  logic [7:0]               count, count_next;   // remaining bytes minus one
  logic [7:0]               addr_hi, addr_hi_next;
  logic                     is_write, is_write_next;
  logic [7:0]               tx_data_next;
  logic                     tx_valid_next;
  logic                     bram_we_next;
  logic                     bram_re_next;
  logic [RAM_ADDR_BITS-1:0] bram_addr_next;
  logic [7:0]               bram_wdata_next;
  logic                     timed_out;

  assign busy     = (state != IDLE);
  assign addr_inc = addr + RAM_ADDR_BITS'(1);

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt, idle_cnt_next;
  logic          wait_state;

  // The timeout applies only while waiting for host bytes.
  assign wait_state = (state == GET_AH) || (state == GET_AL) ||
                      (state == GET_LEN) || (state == WR_DATA);

  always_comb begin
    idle_cnt_next = idle_cnt;
    timed_out     = 1'b0;

    if (state == IDLE || rx_valid) begin
      idle_cnt_next = '0;
    end else if (wait_state) begin
      // The count reaches TIMEOUT_CYCLES-1 after that many silent cycles.
      // The move to IDLE then lands exactly TIMEOUT_CYCLES after the last byte.
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        timed_out = 1'b1;
      end else begin
        idle_cnt_next = idle_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_next;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and output logic.
  // RAM strobes are registered, so each one is requested in the cycle before
  // it is seen on the port.
  always_comb begin
    state_next      = state;
    addr_next       = addr;
    count_next      = count;
    addr_hi_next    = addr_hi;
    is_write_next   = is_write;
    tx_data_next    = tx_data;
    tx_valid_next   = tx_valid;
    bram_we_next    = 1'b0;
    bram_re_next    = 1'b0;
    bram_addr_next  = bram_addr;
    bram_wdata_next = bram_wdata;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            is_write_next = 1'b1;
            state_next    = GET_AH;
          end else if (rx_data == CMD_READ) begin
            is_write_next = 1'b0;
            state_next    = GET_AH;
          end
        end
      end

      GET_AH: begin
        if (rx_valid) begin
          addr_hi_next = rx_data;
          state_next   = GET_AL;
        end
      end

      GET_AL: begin
        if (rx_valid) begin
          addr_next  = RAM_ADDR_BITS'({addr_hi, rx_data});
          state_next = GET_LEN;
        end
      end

      GET_LEN: begin
        if (rx_valid) begin
          count_next = rx_data;
          if (is_write) begin
            state_next = WR_DATA;
          end else begin
            // Schedule the first read pulse for the RD_REQ cycle.
            bram_re_next   = 1'b1;
            bram_addr_next = addr;
            state_next     = RD_REQ;
          end
        end
      end

      WR_DATA: begin
        if (rx_valid) begin
          bram_we_next    = 1'b1;
          bram_addr_next  = addr;
          bram_wdata_next = rx_data;
          addr_next       = addr_inc;

          if (count == 8'd0) begin
            // tx_valid rises together with the final write pulse.
            tx_data_next  = ACK_BYTE;
            tx_valid_next = 1'b1;
            state_next    = WR_ACK;
          end else begin
            count_next = count - 8'd1;
          end
        end
      end

      WR_ACK: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end

      RD_REQ: begin
        state_next = RD_WAIT;
      end

      RD_WAIT: begin
        tx_data_next  = bram_rdata;
        tx_valid_next = 1'b1;
        state_next    = RD_SEND;
      end

      RD_SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          addr_next     = addr_inc;

          if (count == 8'd0) begin
            state_next = IDLE;
          end else begin
            count_next     = count - 8'd1;
            bram_re_next   = 1'b1;
            bram_addr_next = addr_inc;
            state_next     = RD_REQ;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // timed_out is only raised in waiting states with no byte present,
    // so overriding the next state here cannot drop a write pulse.
    if (timed_out) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      addr_hi    <= '0;
      is_write   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      bram_we    <= 1'b0;
      bram_re    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      count      <= count_next;
      addr_hi    <= addr_hi_next;
      is_write   <= is_write_next;
      tx_data    <= tx_data_next;
      tx_valid   <= tx_valid_next;
      bram_we    <= bram_we_next;
      bram_re    <= bram_re_next;
      bram_addr  <= bram_addr_next;
      bram_wdata <= bram_wdata_next;
    end
  end

endmodule

// File: tb/tb_bram_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_uart_cmd_ctrl
//
// Purpose:
//   Self-checking bench for bram_uart_cmd_ctrl.
//   - A behavioural RAM is attached to the DUT port.
//   - The reference model is a plain byte array of expected RAM contents,
//     updated from each command's address, length and data.
//   - Observed RAM writes, TX handshakes and read pulses are collected by a
//     monitor and compared with the model after each command.
//   - When RX_TIMEOUT_EN is defined, the timeout behaviour is also exercised.
// -----------------------------------------------------------------------------
module tb_bram_uart_cmd_ctrl;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          bram_we;
  logic          bram_re;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic [7:0]    bram_rdata = 8'h00;
  logic          busy;

  always #5 clk = ~clk;

  bram_uart_cmd_ctrl #(
    .RAM_ADDR_BITS (AW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bram_we   (bram_we),
    .bram_re   (bram_re),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .busy      (busy)
  );

  // Behavioural RAM with a registered read. It is cleared on the first clock.
  logic [7:0] ram [DEPTH];
  logic       ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
      ram_ready <= 1'b1;
    end else begin
      if (bram_we) ram[bram_addr] <= bram_wdata;
      if (bram_re) bram_rdata <= ram[bram_addr];
    end
  end

  // Reference model and observation queues
  logic [7:0]    ref_mem [DEPTH];
  logic [7:0]    wbuf [256];
  logic [7:0]    tx_q [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [7:0]    wr_data_q [$];
  int            re_pulses = 0;
  int            ready_mode = 0;   // 0: ready high, 1: random, 2: held low
  int            total = 0;
  int            passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // TX ready driver
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  // - Samples away from the active edge.
  // - A handshake is recorded when it will complete at the next rising edge.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(hold_data));
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;

      if (tx_valid && tx_ready) tx_q.push_back(tx_data);

      if (bram_we) begin
        wr_addr_q.push_back(bram_addr);
        wr_data_q.push_back(bram_wdata);
      end

      if (bram_re) re_pulses++;

      if (bram_we || bram_re) chk("we_re_exclusive", 32'(bram_we & bram_re), 32'd0);
    end
  end

  task automatic clear_obs();
    tx_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    re_pulses = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic do_write(input logic [15:0] a16, input int n);
    int base;
    int ea;
    base = int'(a16) % DEPTH;
    clear_obs();

    send_byte(8'h57);
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) send_byte(wbuf[i]);

    wait_idle("wr_idle");
    chk("wr_count", 32'(wr_addr_q.size()), 32'(n));

    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      ea = (base + i) % DEPTH;
      chk("wr_addr", 32'(wr_addr_q[i]), 32'(ea));
      chk("wr_data", 32'(wr_data_q[i]), 32'(wbuf[i]));
    end

    for (int i = 0; i < n; i++) ref_mem[(base + i) % DEPTH] = wbuf[i];

    chk("ack_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) chk("ack_byte", 32'(tx_q[0]), 32'h06);
  endtask

  task automatic do_read(input logic [15:0] a16, input int n, input bit junk);
    int base;
    base = int'(a16) % DEPTH;
    clear_obs();

    send_byte(8'h52);
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    send_byte(8'(n - 1));

    // Bytes arriving during the read burst must be ignored.
    if (junk) begin
      send_byte(8'h52);
      send_byte(8'h57);
      send_byte(8'h41);
    end

    wait_idle("rd_idle");
    chk("rd_count", 32'(tx_q.size()), 32'(n));

    for (int i = 0; i < n && i < tx_q.size(); i++)
      chk("rd_data", 32'(tx_q[i]), 32'(ref_mem[(base + i) % DEPTH]));

    chk("rd_re_pulses", 32'(re_pulses), 32'(n));
    chk("rd_no_write", 32'(wr_addr_q.size()), 32'd0);
  endtask

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time (passed %0d of %0d)", passed, total);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    // Reset state
    ready_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_tx_valid", 32'(tx_valid),  32'd0);
    chk("rst_tx_data",  32'(tx_data),   32'd0);
    chk("rst_we",       32'(bram_we),   32'd0);
    chk("rst_re",       32'(bram_re),   32'd0);
    chk("rst_addr",     32'(bram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write
    wbuf[0] = 8'hA5;
    do_write(16'h0010, 1);

    // Preload 0x0010..0x0013, then burst read with backpressure and junk RX bytes
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    wbuf[3] = 8'h44;
    do_write(16'h0010, 4);
    ready_mode = 1;
    do_read(16'h0010, 4, 1'b1);

    // Garbage byte in IDLE
    clear_obs();
    send_byte(8'h41);
    chk("garbage_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("garbage_no_tx", 32'(tx_q.size() + wr_addr_q.size() + re_pulses), 32'd0);

    // Wrap-around write and readback
    ready_mode = 0;
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    do_write(16'h1FFF, 2);
    do_read(16'h1FFF, 2, 1'b0);

    // Reset in RD_SEND
    ready_mode = 2;
    clear_obs();
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h03);
    begin
      int n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid_rst_reached_send", 32'(tx_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_re",       32'(bram_re),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    do_read(16'h0010, 4, 1'b0);

`ifdef RX_TIMEOUT_EN
    // Header abandoned -> IDLE after 100 silent cycles
    clear_obs();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h20);
    repeat (110) @(negedge clk);
    #2;
    chk("to_busy",     32'(busy),             32'd0);
    chk("to_no_write", 32'(wr_addr_q.size()), 32'd0);
    chk("to_no_tx",    32'(tx_q.size()),      32'd0);
    do_read(16'h0020, 1, 1'b0);
`endif

    // Maximum-length burst across the top of the address space
    for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
    do_write(16'hFF80, 256);
    do_read(16'h1F80, 256, 1'b0);

    // Randomized write/readback pairs
    for (int t = 0; t < 12; t++) begin
      logic [15:0] a;
      int          n;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'h1FF8 + 16'($urandom_range(0, 7));
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);

      ready_mode = $urandom_range(0, 1);
      do_write(a, n);

      ready_mode = $urandom_range(0, 1);
      do_read(a + 16'($urandom_range(0, 3)), $urandom_range(1, 24), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
